// File: rtl/i2c_mon_pkg.sv
// i2c_mon_pkg: shared event types, decoder states and timestamp width for the I2C bus monitor
package i2c_mon_pkg;
   localparam int TS_W = 16;
   typedef enum logic [1:0] {EVT_START, EVT_RSTART, EVT_STOP, EVT_BYTE} evt_type_e;
   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ACK} chan_state_e;
   typedef struct packed {
      logic [3:0]      ch;
      evt_type_e       evt_type;
      logic [7:0]      data;
      logic            ack;
      logic            addr;
      logic [TS_W-1:0] ts;
   } evt_rec_t;
endpackage

// File: rtl/i2c_mon_chan.sv
// i2c_mon_chan: per-bus synchroniser, START/STOP/byte decoder and one-entry holding register
module i2c_mon_chan
   import i2c_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sda,
   input  logic            scl,
   input  logic [3:0]      ch,
   input  logic [TS_W-1:0] ts,
   input  logic            grant,
   output logic            hold_valid,
   output evt_rec_t        hold_rec,
   output logic            busy,
   output logic            drop
);
   logic [SYNC_STAGES-1:0] sda_s, scl_s;
   logic sda_p, scl_p, sda_c, scl_c, start, stop, rise, byte_done, new_evt, addr_f;
   logic [3:0] cnt;
   logic [7:0] sr;
   chan_state_e state, state_n;
   evt_rec_t new_rec;

   assign sda_c = sda_s[SYNC_STAGES-1];
   assign scl_c = scl_s[SYNC_STAGES-1];

   // lines reset high so a released reset never looks like a START
   always_ff @(posedge clk)
      if (rst) begin
         sda_s <= '1;
         scl_s <= '1;
         sda_p <= 1'b1;
         scl_p <= 1'b1;
      end else begin
         sda_s <= {sda_s[SYNC_STAGES-2:0], sda};
         scl_s <= {scl_s[SYNC_STAGES-2:0], scl};
         sda_p <= sda_c;
         scl_p <= scl_c;
      end

   always_ff @(posedge clk) state <= rst ? ST_IDLE : state_n;

   always_comb begin
      start     = scl_c & scl_p & sda_p & ~sda_c;
      stop      = scl_c & scl_p & ~sda_p & sda_c;
      rise      = scl_c & ~scl_p;
      busy      = state != ST_IDLE;
      byte_done = rise & (state == ST_ACK);
      new_evt   = start | stop | byte_done;
      drop      = new_evt & hold_valid & ~grant;
      state_n   = stop ? ST_IDLE : start ? ST_DATA : !rise ? state :
                  (state == ST_ACK) ? ST_DATA :
                  (state == ST_DATA && cnt == 4'd7) ? ST_ACK : state;
      new_rec.ch       = ch;
      new_rec.evt_type = stop ? EVT_STOP : start ? (busy ? EVT_RSTART : EVT_START) : EVT_BYTE;
      new_rec.data     = byte_done ? sr : 8'h00;
      new_rec.ack      = byte_done & ~sda_c;
      new_rec.addr     = byte_done & addr_f;
      new_rec.ts       = ts;
   end

   always_ff @(posedge clk)
      if (rst) begin
         cnt        <= '0;
         sr         <= '0;
         addr_f     <= 1'b0;
         hold_valid <= 1'b0;
         hold_rec   <= '0;
      end else begin
         if (start || stop) begin
            cnt    <= '0;
            addr_f <= start;
         end else if (rise && state == ST_DATA) begin
            sr  <= {sr[6:0], sda_c};
            cnt <= cnt + 4'd1;
         end else if (byte_done) begin
            cnt    <= '0;
            addr_f <= 1'b0;
         end
         if (new_evt && (!hold_valid || grant)) begin
            hold_valid <= 1'b1;
            hold_rec   <= new_rec;
         end else if (grant)
            hold_valid <= 1'b0;
      end
endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: multi-channel passive I2C event monitor with round-robin arbiter and event FIFO.
// Define I2C_MON_TIMESTAMP_EN to stamp each record with a 16-bit free-running cycle count.
module i2c_bus_monitor
   import i2c_mon_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                                        pclk_i,
   input  logic                                        preset_i,
   input  logic [NUM_CH-1:0]                           sda_i,
   input  logic [NUM_CH-1:0]                           scl_i,
   output logic                                        evt_valid_o,
   input  logic                                        evt_ready_i,
   output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] evt_ch_o,
   output logic [1:0]                                  evt_type_o,
   output logic [7:0]                                  evt_data_o,
   output logic                                        evt_ack_o,
   output logic                                        evt_addr_o,
   output logic [15:0]                                 evt_ts_o,
   output logic [NUM_CH-1:0]                           busy_o,
   output logic [7:0]                                  drop_cnt_o
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [TS_W-1:0] ts;
   logic [NUM_CH-1:0] hold_valid, grant, drop;
   evt_rec_t hold_rec [NUM_CH];
   evt_rec_t mem [FIFO_DEPTH];
   logic [AW:0] wp, rp;
   logic [AW-1:0] ra;
   logic [CW-1:0] ptr, win;
   logic found, push, pop, full, empty;

`ifdef I2C_MON_TIMESTAMP_EN
   always_ff @(posedge pclk_i) ts <= preset_i ? '0 : ts + 16'd1;
   assign evt_ts_o = evt_valid_o ? mem[ra].ts : '0;
`else
   assign ts       = '0;
   assign evt_ts_o = '0;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      i2c_mon_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
         .clk(pclk_i), .rst(preset_i), .sda(sda_i[c]), .scl(scl_i[c]), .ch(4'(c)), .ts(ts),
         .grant(grant[c]), .hold_valid(hold_valid[c]), .hold_rec(hold_rec[c]),
         .busy(busy_o[c]), .drop(drop[c])
      );
   end

   // first pending channel at or after the priority pointer wins
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (!found && hold_valid[(int'(ptr) + k) % NUM_CH]) begin
            found = 1'b1;
            win   = CW'((int'(ptr) + k) % NUM_CH);
         end
      pop   = evt_valid_o & evt_ready_i;
      push  = found & (!full | pop);
      grant = push ? NUM_CH'(1) << win : '0;
   end

   assign ra          = rp[AW-1:0];
   assign empty       = wp == rp;
   assign full        = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign evt_valid_o = !empty;
   assign evt_ch_o    = evt_valid_o ? mem[ra].ch[CW-1:0] : '0;
   assign evt_type_o  = evt_valid_o ? mem[ra].evt_type : EVT_START;
   assign evt_data_o  = evt_valid_o ? mem[ra].data : 8'h00;
   assign evt_ack_o   = evt_valid_o & mem[ra].ack;
   assign evt_addr_o  = evt_valid_o & mem[ra].addr;

   always_ff @(posedge pclk_i)
      if (preset_i) begin
         wp  <= '0;
         rp  <= '0;
         ptr <= '0;
      end else begin
         if (push) begin
            wp  <= wp + 1'b1;
            ptr <= (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
      end

   always_ff @(posedge pclk_i) if (push) mem[wp[AW-1:0]] <= hold_rec[win];

   always_ff @(posedge pclk_i)
      drop_cnt_o <= preset_i ? '0 : (int'(drop_cnt_o) + $countones(drop) > 255) ? 8'hFF
                               : drop_cnt_o + 8'($countones(drop));
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: transaction-level I2C stimulus with an expected-record scoreboard drained by a monitor
`timescale 1ns/1ps
module tb_i2c_bus_monitor;
   localparam int NUM_CH = 4, FIFO_DEPTH = 16, HP = 10;
   typedef struct {int ch; int typ; int data; int ack; int addr; int ts_delta;} exp_t;

   logic pclk_i = 1'b0, preset_i = 1'b1, evt_ready_i = 1'b0;
   logic [NUM_CH-1:0] sda_i = '1, scl_i = '1;
   logic evt_valid_o, evt_ack_o, evt_addr_o;
   logic [1:0] evt_ch_o, evt_type_o;
   logic [7:0] evt_data_o, drop_cnt_o;
   logic [15:0] evt_ts_o, prev_ts = '0;
   logic [NUM_CH-1:0] busy_o, m_busy = '0, m_first = '0;
   int tests = 0, fails = 0, ready_mode = 1, blocked_cnt = 0, exp_drop = 0;
   int rc, nb;
   bit blocked = 0;
   logic [NUM_CH-1:0] rm;
   exp_t q[$];
   exp_t mon_e;

   i2c_bus_monitor #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
      .pclk_i(pclk_i), .preset_i(preset_i), .sda_i(sda_i), .scl_i(scl_i),
      .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_ch_o(evt_ch_o),
      .evt_type_o(evt_type_o), .evt_data_o(evt_data_o), .evt_ack_o(evt_ack_o),
      .evt_addr_o(evt_addr_o), .evt_ts_o(evt_ts_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // consumer: random, held low or held high depending on the test phase
   initial forever begin
      @(posedge pclk_i);
      #1;
      evt_ready_i = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
   end

   always @(negedge pclk_i)
      if (!preset_i && evt_valid_o && evt_ready_i) begin
         if (q.size() == 0) check("unexpected_record", 1, 0);
         else begin
            mon_e = q.pop_front();
            check($sformatf("record ch%0d type%0d", mon_e.ch, mon_e.typ),
                  {evt_ch_o, evt_type_o, evt_data_o, evt_ack_o, evt_addr_o},
                  {2'(mon_e.ch), 2'(mon_e.typ), 8'(mon_e.data), 1'(mon_e.ack), 1'(mon_e.addr)});
`ifdef I2C_MON_TIMESTAMP_EN
            if (mon_e.ts_delta >= 0) check("ts_delta", 16'(evt_ts_o - prev_ts), mon_e.ts_delta);
            prev_ts = evt_ts_o;
`else
            check("ts_zero", evt_ts_o, 0);
`endif
         end
      end

   task automatic exp_push(input int ch, input int typ, input int data, input int ack, input int addr, input int dl);
      if (blocked && blocked_cnt >= FIFO_DEPTH + 1) exp_drop++;
      else begin
         q.push_back('{ch, typ, data, ack, addr, dl});
         if (blocked) blocked_cnt++;
      end
   endtask

   task automatic set_sda(input logic [NUM_CH-1:0] m, input logic v);
      for (int i = 0; i < NUM_CH; i++) if (m[i]) sda_i[i] = v;
      repeat (HP) @(posedge pclk_i);
      #1;
   endtask

   task automatic set_scl(input logic [NUM_CH-1:0] m, input logic v);
      for (int i = 0; i < NUM_CH; i++) if (m[i]) scl_i[i] = v;
      repeat (HP) @(posedge pclk_i);
      #1;
   endtask

   task automatic i2c_start(input logic [NUM_CH-1:0] m);
      set_sda(m, 1'b1);
      set_scl(m, 1'b1);
      for (int i = 0; i < NUM_CH; i++) if (m[i]) begin
         exp_push(i, m_busy[i] ? 1 : 0, 0, 0, 0, -1);
         m_busy[i]  = 1'b1;
         m_first[i] = 1'b1;
      end
      set_sda(m, 1'b0);
      check("busy_after_start", busy_o, m_busy);
      set_scl(m, 1'b0);
   endtask

   task automatic send_bits(input logic [NUM_CH-1:0] m, input logic [8:0] v, input int n);
      for (int b = 8; b > 8 - n; b--) begin
         set_sda(m, v[b]);
         set_scl(m, 1'b1);
         set_scl(m, 1'b0);
      end
   endtask

   task automatic send_byte(input logic [NUM_CH-1:0] m, input logic [7:0] d, input logic ack);
      for (int i = 0; i < NUM_CH; i++) if (m[i]) begin
         exp_push(i, 3, d, ack, m_first[i], -1);
         m_first[i] = 1'b0;
      end
      send_bits(m, {d, ~ack}, 9);
   endtask

   task automatic i2c_stop(input logic [NUM_CH-1:0] m);
      set_scl(m, 1'b0);
      set_sda(m, 1'b0);
      set_scl(m, 1'b1);
      for (int i = 0; i < NUM_CH; i++) if (m[i]) begin
         exp_push(i, 2, 0, 0, 0, -1);
         m_busy[i] = 1'b0;
      end
      set_sda(m, 1'b1);
      check("busy_after_stop", busy_o, m_busy);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && q.size() > 0; i++) @(posedge pclk_i);
      repeat (20) @(posedge pclk_i);
      #1;
      check("queue_drained", q.size(), 0);
      check("fifo_empty", evt_valid_o, 0);
   endtask

   task automatic do_reset();
      preset_i = 1'b1;
      sda_i    = '1;
      scl_i    = '1;
      repeat (4) @(posedge pclk_i);
      #1;
      q.delete();
      m_busy  = '0;
      m_first = '0;
      check("reset_outputs", {evt_valid_o, busy_o, drop_cnt_o, evt_ch_o, evt_type_o, evt_data_o,
                              evt_ack_o, evt_addr_o, evt_ts_o}, 0);
      preset_i = 1'b0;
      repeat (5) @(posedge pclk_i);
      #1;
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: time limit reached with %0d records pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      i2c_start(4'b0001);
      send_byte(4'b0001, 8'hA0, 1'b1);
      send_byte(4'b0001, 8'h5A, 1'b0);
      i2c_stop(4'b0001);
      drain();
      i2c_start(4'b0010);
      send_byte(4'b0010, 8'h42, 1'b1);
      i2c_start(4'b0010);
      send_byte(4'b0010, 8'h43, 1'b0);
      i2c_stop(4'b0010);
      drain();
      do_reset();
      i2c_stop(4'b1111);
      i2c_start(4'b1111);
      i2c_stop(4'b1111);
      drain();
      ready_mode = 0;
      repeat (3) @(posedge pclk_i);
      #1;
      blocked     = 1;
      blocked_cnt = 0;
      exp_drop    = 0;
      repeat (10) begin
         i2c_start(4'b0100);
         i2c_stop(4'b0100);
      end
      check("drop_cnt", drop_cnt_o, exp_drop);
      check("fifo_held_while_blocked", evt_valid_o, 1);
      blocked    = 0;
      ready_mode = 1;
      drain();
      i2c_start(4'b0001);
      send_bits(4'b0001, 9'h1A5, 4);
      do_reset();
      i2c_start(4'b0001);
      send_byte(4'b0001, 8'h3C, 1'b1);
      i2c_stop(4'b0001);
      drain();
      exp_push(3, 0, 0, 0, 0, -1);
      exp_push(3, 2, 0, 0, 0, 50);
      exp_push(3, 0, 0, 0, 0, 50);
      m_busy[3]  = 1'b1;
      m_first[3] = 1'b1;
      sda_i[3] = 1'b0;
      repeat (50) @(posedge pclk_i);
      #1;
      sda_i[3] = 1'b1;
      repeat (50) @(posedge pclk_i);
      #1;
      sda_i[3] = 1'b0;
      repeat (HP) @(posedge pclk_i);
      #1;
      i2c_stop(4'b1000);
      drain();
      ready_mode = 2;
      repeat (8) begin
         rc = $urandom_range(0, NUM_CH - 1);
         rm = NUM_CH'(1) << rc;
         i2c_start(rm);
         nb = $urandom_range(1, 3);
         repeat (nb) send_byte(rm, 8'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            i2c_start(rm);
            send_byte(rm, 8'($urandom), 1'($urandom));
         end
         i2c_stop(rm);
      end
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
